// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the memory-slave FSM state type.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // Beat count of a wrapping burst; 0 for every non-wrapping burst type.
  function automatic logic [4:0] wrap_beats(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4:  return 5'd4;
      HBURST_WRAP8:  return 5'd8;
      HBURST_WRAP16: return 5'd16;
      default:       return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// Expected address of the next beat of an INCR/WRAP burst. Purely
// combinational so the master can share it.
module ahb_burst_addr_calc import ahb_lite_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [2:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_len;
  logic [ADDR_W-1:0] wrap_mask;

  // Incrementing bursts step by the transfer size; wrapping bursts keep the
  // upper bits and wrap the low bits inside a beats*size window.
  always_comb begin
    incr_addr = addr + (ADDR_W'(1) << size);
    wrap_len  = ADDR_W'(wrap_beats(burst)) << size;
    wrap_mask = wrap_len - ADDR_W'(1);
    if (wrap_len != '0) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Parametrised AHB-Lite memory slave: byte-lane writes, optional wait states
// on NONSEQ, SEQ address tracking and a two-cycle ERROR response.
module ahb_lite_mem_slave import ahb_lite_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [2:0]        dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int WORD_W = $clog2(DEPTH);
  localparam int OFF_W  = LANE_W + WORD_W;
  localparam logic [2:0] MAX_SIZE = 3'(LANE_W);

  slv_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OFF_W-1:0]    addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic                trk_valid_q;
  logic [ADDR_W-1:0]   exp_addr_q;
  logic [ADDR_W-1:0]   calc_next;
  logic [LANE_W-1:0]   size_mask;
  logic                accept, illegal, capture;
  logic [STRB_W-1:0]   be;
  logic [WORD_W-1:0]   word_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Handshake: an address phase is taken only when the slave is selected, the
  // bus is ready (previous data phase ends this edge) and HTRANS is NONSEQ/SEQ;
  // IDLE/BUSY are answered zero-wait OKAY and leave tracking untouched.
  assign accept   = HSEL & HREADY & HTRANS[1];
  assign word_idx = addr_q[OFF_W-1:LANE_W];

  ahb_burst_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
    .addr      (HADDR),
    .size      (HSIZE),
    .burst     (HBURST),
    .next_addr (calc_next)
  );

  // Legality of the current address phase: range, alignment, size, SEQ address.
  always_comb begin
    size_mask = LANE_W'((32'd1 << HSIZE) - 32'd1);
    illegal   = (HADDR[ADDR_W-1:OFF_W] != '0)
             || ((HADDR[LANE_W-1:0] & size_mask) != '0)
             || (HSIZE > MAX_SIZE)
             || ((HTRANS == HTRANS_SEQ) && (!trk_valid_q || (HADDR != exp_addr_q)));
  end

  // Next-state: IDLE, DATA and ERR2 all take the pipelined address phase.
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? ST_DATA : ST_WAIT;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          capture = 1'b1;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if ((HTRANS == HTRANS_NONSEQ) && (WAIT_STATES > 0)) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // State, wait counter, captured transfer and burst tracking registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      trk_valid_q <= 1'b0;
      exp_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q      <= HADDR[OFF_W-1:0];
        write_q     <= HWRITE;
        size_q      <= HSIZE;
        exp_addr_q  <= calc_next;
        trk_valid_q <= (HBURST != HBURST_SINGLE);
      end
    end
  end

  // Byte lanes covered by the captured size at the captured lane offset.
  always_comb begin
    be = '0;
    for (int i = 0; i < STRB_W; i++) begin
      be[i] = (i >= int'(addr_q[LANE_W-1:0]))
           && (i < int'(addr_q[LANE_W-1:0]) + (1 << size_q));
    end
  end

  // Commit write lanes at the edge that ends the data phase; reset wins.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == ST_DATA) && write_q) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA    = (((state_q == ST_WAIT) || (state_q == ST_DATA)) && !write_q)
                   ? mem[word_idx] : '0;
  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign dbg_state = state_q;

endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

Parametrised AHB-Lite memory slave that supersedes the fixed 32-bit, word-only slave memories behind the bus decoder. It supports configurable data width, depth and wait-state insertion, and byte/halfword/word writes with lane masking. It tracks SEQ beat addresses of INCR/WRAP bursts and signals a two-cycle ERROR on illegal transfers. It sits on one HSELx output of the decoder and drives the read-data/response mux.

## Interface
- DATA_W, 32: data bus width; 32 or 64.
- ADDR_W, 32: HADDR width.
- DEPTH, 1024: memory words of DATA_W bits; power of two.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted on every NONSEQ data phase; 0..15.

- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
- HBURST  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- HWDATA  in  DATA_W  write data, valid in data phase.
- HREADY  in  1  bus-wide ready (mux output).
- HRDATA  out  DATA_W  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- The slave samples the address phase when HSEL & HREADY & HTRANS[1]. It captures addr, write, size, burst and a `nonseq` flag.
- IDLE/BUSY with HSEL and HREADY: zero-wait OKAY. BUSY leaves burst tracking unchanged.
- A transfer is illegal if any of these hold:
  - offset (HADDR mod DEPTH*DATA_W/8) ≠ HADDR, i.e. out of range;
  - HADDR is not aligned to 2^HSIZE;
  - 2^HSIZE > DATA_W/8;
  - it is a SEQ beat whose HADDR ≠ the tracked expected address.
- Expected next address, with b = 2^size:
  - INCR/INCRx: addr + b.
  - WRAPx (L = beats·b): (addr & ~(L−1)) | ((addr + b) & (L−1)).
  - Beat count is not enforced. A NONSEQ always restarts tracking.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE → WAIT on a legal NONSEQ when WAIT_STATES>0; → DATA on a legal NONSEQ when WAIT_STATES=0, or on a legal SEQ; → ERR1 on an illegal transfer.
  - WAIT: HREADYOUT=0; the counter decrements; → DATA when it reaches 1.
  - DATA: HREADYOUT=1. The next state follows the pipelined address phase, using the same rules as IDLE; with no accepted transfer → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; memory untouched; → IDLE, or takes the next address phase as IDLE does.
- Write: on the DATA-state edge, the byte lanes selected by size and addr[log2(DATA_W/8)-1:0] are updated from HWDATA. Other lanes are preserved.
- Read: HRDATA = mem[addr word] in WAIT/DATA when the captured transfer is a read; 0 otherwise. Unselected lanes return memory contents.

## Timing
- Reset (HRESET=1 at an edge): next cycle HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, tracking cleared. Memory is not cleared.
- Reset during WAIT or ERR1 aborts the transfer. A pending write is not committed.
- NONSEQ latency is 1 + WAIT_STATES data-phase cycles; SEQ latency is 1 cycle.
- A read issued immediately after a write to the same word returns the new data. The write commits at the edge that ends its data phase.
- With HREADY=0 from another slave, no address phase is sampled and the state is held.
- An ERROR in a burst does not cancel tracking. A subsequent SEQ is still checked against the expected address after the erroneous beat.

## Structure
- Shared package `ahb_lite_pkg`: HTRANS, HBURST, HSIZE and HRESP encodings, and the FSM state enum.
- Sub-module `ahb_burst_addr_calc`: combinational expected-next-address from (addr, size, burst). It is reused by the master.

## Test plan
Parameters for all scenarios: DATA_W=32, DEPTH=1024, WAIT_STATES=2.

- Single write 0x3C ← 60, then read 0x3C: HREADYOUT low for 2 cycles on each transfer; HRDATA=60, HRESP=0.
- INCR4 write at 60 with data 60/64/68/72: first beat has 2 waits, SEQ beats 0 waits. Reads of 60..72 return 60..72.
- WRAP4 at 100 via 100/104/108/96 → all OKAY. A repeat with a fourth beat at 112 → ERR1/ERR2, and mem[112] is unchanged.
- Word 0x40 = 0x11223344, then byte write at 0x41 with HWDATA=0x0000AB00 → read 0x40 = 0x1122AB44. A halfword at 0x41 → ERROR.
- Read at 4096 (out of range) → two-cycle ERROR, HRDATA=0. The next NONSEQ at 0 proceeds with OKAY.
- HRESET asserted during the second wait cycle of a write to 0x80 ← 5: next cycle HREADYOUT=1, HRESP=0. A later read of 0x80 returns its prior value.
